// File: rtl/sram_pkg.sv
// Package: sram_pkg
// Shared state encoding and geometry constants for the cache-side SRAM
// controller and its phase counter.
package sram_pkg;

    localparam int SRAM_ADDR_W = 18;  // halfword address width at the pads
    localparam int SRAM_DQ_W   = 16;  // pad data width
    localparam int RD_PHASES   = 4;   // halfwords per read block
    localparam int WR_PHASES   = 2;   // halfwords per written word
    localparam int PHASE_W     = 2;   // enough bits to index RD_PHASES

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sram_phase_counter.sv
// Module: sram_phase_counter
// Wait counter (0..WAIT_CYCLES-1) nested inside a phase counter. Both sit at
// zero while en is low, so every transaction starts at phase 0, count 0.
// wait_wrap marks the last clock of a phase; phase_wrap marks the last clock
// of the final phase (phase == last_phase).
module sram_phase_counter
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PHASE_W-1:0] last_phase,
    output logic [PHASE_W-1:0] phase,
    output logic               wait_wrap,
    output logic               phase_wrap
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;

    assign wait_wrap  = (cnt == CNT_W'(WAIT_CYCLES - 1));
    assign phase_wrap = wait_wrap && (phase == last_phase);

    // Advance the wait count each clock; step the phase when it wraps.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values, independent of block ordering.
        if (rst) begin
            cnt   <= '0;
            phase <= '0;
        end else if (!en) begin
            cnt   <= '0;
            phase <= '0;
        end else if (wait_wrap) begin
            cnt   <= '0;
            phase <= phase_wrap ? '0 : phase + 1'b1;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// Module: sram_controller
// Responder for cache word read/write requests, driving a 16-bit async SRAM.
// A read fetches a 64-bit block as four halfwords; a write stores one 32-bit
// word as two halfwords. Each halfword is held on the pins WAIT_CYCLES clocks.
// Optional: define SRAM_PERF_CNT_EN to add rd_count/wr_count outputs.
module sram_controller
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DQ_W        = SRAM_DQ_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         address,
    input  logic [31:0]         wdata,
    input  logic                mem_r_en,
    input  logic                mem_w_en,
    output logic [4*DQ_W-1:0]   rdata,
    output logic                ready,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DQ_W-1:0]     sram_dq_o,
    output logic                sram_dq_oe,
    input  logic [DQ_W-1:0]     sram_dq_i,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n,
    output logic                sram_ub_n,
    output logic                sram_lb_n
`ifdef SRAM_PERF_CNT_EN
    ,
    output logic [31:0]         rd_count,
    output logic [31:0]         wr_count
`endif
);

    state_t              state_q, state_d;
    logic [ADDR_W-2:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [PHASE_W-1:0]  phase;
    logic [PHASE_W-1:0]  last_phase;
    logic                wait_wrap;
    logic                phase_wrap;
    logic                start;
    logic                unused_addr_hi;

    // Word address bits above the SRAM's reach are not decoded.
    assign unused_addr_hi = ^address[31:ADDR_W-1];

    assign start      = (state_q == ST_IDLE) && (mem_r_en || mem_w_en);
    assign last_phase = (state_q == ST_WR) ? PHASE_W'(WR_PHASES - 1)
                                           : PHASE_W'(RD_PHASES - 1);
    assign ready      = (state_q == ST_DONE) ||
                        ((state_q == ST_IDLE) && !mem_r_en && !mem_w_en);

    sram_phase_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_phase_counter (
        .clk        (clk),
        .rst        (rst),
        .en         ((state_q == ST_RD) || (state_q == ST_WR)),
        .last_phase (last_phase),
        .phase      (phase),
        .wait_wrap  (wait_wrap),
        .phase_wrap (phase_wrap)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: write wins when both requests are present in IDLE.
    always_comb begin
        // NOTE: next-state gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (mem_w_en)      state_d = ST_WR;
                     else if (mem_r_en) state_d = ST_RD;
            ST_RD,
            ST_WR:   if (phase_wrap)    state_d = ST_DONE;
            ST_DONE:                    state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // Latch the request operands on IDLE exit; later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (start) begin
            addr_q  <= address[ADDR_W-2:0];
            wdata_q <= wdata;
        end
    end

    // Capture each read halfword on the last clock of its phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else if ((state_q == ST_RD) && wait_wrap)
            rdata[DQ_W*phase +: DQ_W] <= sram_dq_i;
    end

    // Pin decode from registered state only. we_n rises one clock before the
    // phase ends so address and data stay stable past its rising edge.
    always_comb begin
        sram_addr  = '0;
        sram_dq_o  = '0;
        sram_dq_oe = 1'b0;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_ub_n  = 1'b1;
        sram_lb_n  = 1'b1;
        unique case (state_q)
            ST_RD: begin
                sram_addr = {addr_q[ADDR_W-2:1], phase};
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_ub_n = 1'b0;
                sram_lb_n = 1'b0;
            end
            ST_WR: begin
                sram_addr  = {addr_q, phase[0]};
                sram_dq_o  = phase[0] ? wdata_q[31:16] : wdata_q[15:0];
                sram_dq_oe = 1'b1;
                sram_ce_n  = 1'b0;
                sram_ub_n  = 1'b0;
                sram_lb_n  = 1'b0;
                sram_we_n  = !((WAIT_CYCLES == 1) || !wait_wrap);
            end
            default: ;
        endcase
    end

`ifdef SRAM_PERF_CNT_EN
    logic is_wr_q;

    // Count completed transactions by kind as they leave DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_wr_q  <= 1'b0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (start) is_wr_q <= mem_w_en;
            if (state_q == ST_DONE) begin
                if (is_wr_q) wr_count <= wr_count + 32'd1;
                else         rd_count <= rd_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Testbench: tb_sram_controller
// Directed checks of sram_controller: a WAIT_CYCLES=2 instance against a
// halfword SRAM model, and a WAIT_CYCLES=1 instance for back-to-back reads.
// Honours SRAM_PERF_CNT_EN when defined.
module tb_sram_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // WAIT_CYCLES=2 instance
    logic [31:0] address = '0, wdata = '0;
    logic        mem_r_en = 1'b0, mem_w_en = 1'b0;
    logic [63:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    logic [15:0] mem [0:255];

    // WAIT_CYCLES=1 instance
    logic [31:0] address_1 = '0, wdata_1 = '0;
    logic        mem_r_en_1 = 1'b0, mem_w_en_1 = 1'b0;
    logic [63:0] rdata_1;
    logic        ready_1;
    logic [17:0] sram_addr_1;
    logic [15:0] sram_dq_o_1, sram_dq_i_1;
    logic        sram_dq_oe_1, sram_ce_n_1, sram_oe_n_1, sram_we_n_1, sram_ub_n_1, sram_lb_n_1;

`ifdef SRAM_PERF_CNT_EN
    logic [31:0] rd_count, wr_count, rd_count_1, wr_count_1;
`endif

    // SRAM read path; writes are applied by the test tasks while we_n is low.
    assign sram_dq_i   = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'h0;
    assign sram_dq_i_1 = (!sram_ce_n_1 && !sram_oe_n_1) ?
                         (16'hA000 | {14'd0, sram_addr_1[1:0]}) : 16'h0;

    sram_controller #(.WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .rdata(rdata), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
`ifdef SRAM_PERF_CNT_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    sram_controller #(.WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst(rst), .address(address_1), .wdata(wdata_1),
        .mem_r_en(mem_r_en_1), .mem_w_en(mem_w_en_1), .rdata(rdata_1), .ready(ready_1),
        .sram_addr(sram_addr_1), .sram_dq_o(sram_dq_o_1), .sram_dq_oe(sram_dq_oe_1),
        .sram_dq_i(sram_dq_i_1), .sram_ce_n(sram_ce_n_1), .sram_oe_n(sram_oe_n_1),
        .sram_we_n(sram_we_n_1), .sram_ub_n(sram_ub_n_1), .sram_lb_n(sram_lb_n_1)
`ifdef SRAM_PERF_CNT_EN
        , .rd_count(rd_count_1), .wr_count(wr_count_1)
`endif
    );

    // {ready, sram_addr, ce_n, oe_n, we_n, ub_n, lb_n, dq_oe}
    localparam logic [24:0] IDLE_PINS = {1'b1, 18'd0, 6'b111110};

    function automatic logic [24:0] pins();
        return {ready, sram_addr, sram_ce_n, sram_oe_n, sram_we_n,
                sram_ub_n, sram_lb_n, sram_dq_oe};
    endfunction

    logic [63:0] block_20_23 = 64'h4444_3333_2222_1111;

    task automatic test_reset;
        #3;
        vectors++;
        if (pins() !== IDLE_PINS) begin
            miscompares++;
            $display("FAIL reset_pins: got %h want %h", pins(), IDLE_PINS);
        end
        vectors++;
        if (rdata !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h want 0", rdata);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (pins() !== IDLE_PINS) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %h want %h", pins(), IDLE_PINS);
        end
    endtask

    // Called #1 after a clock edge; that clock period is cycle 0.
    task automatic run_read(input logic [31:0] addr, input logic [63:0] exp_rd,
                            input string tag);
        int          ready_at = -1;
        logic [17:0] base;
        logic [24:0] exp_pins;
        base = {addr[16:1], 2'b00};
        address = addr; mem_r_en = 1'b1; mem_w_en = 1'b0;
        #1;
        vectors++;
        if (ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s req_ready: got %b want 0", tag, ready);
        end
        for (int n = 1; n <= 20 && ready_at < 0; n++) begin
            @(posedge clk); #1;
            if (n <= 8) begin
                exp_pins = {1'b0, base + 18'((n - 1) / 2), 6'b001000};
                vectors++;
                if (pins() !== exp_pins) begin
                    miscompares++;
                    $display("FAIL %s pins_c%0d: got %h want %h", tag, n, pins(), exp_pins);
                end
            end
            if (ready === 1'b1) begin
                ready_at = n;
                mem_r_en = 1'b0;
            end
        end
        vectors++;
        if (ready_at != 9) begin
            miscompares++;
            $display("FAIL %s ready_cycle: got %0d want 9", tag, ready_at);
        end
        vectors++;
        if (rdata !== exp_rd) begin
            miscompares++;
            $display("FAIL %s rdata: got %h want %h", tag, rdata, exp_rd);
        end
        @(posedge clk); #1;
        vectors++;
        if (pins() !== IDLE_PINS) begin
            miscompares++;
            $display("FAIL %s back_to_idle: got %h want %h", tag, pins(), IDLE_PINS);
        end
    endtask

    // both=1 raises mem_r_en alongside mem_w_en; otherwise mem_w_en is
    // dropped mid-transaction. Operand inputs are scrambled after cycle 1.
    task automatic run_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic both, input logic [63:0] exp_rd,
                             input string tag);
        int          ready_at = -1;
        int          we_lows  = 0;
        int          idx;
        int          p;
        logic [24:0] exp_pins;
        logic [15:0] exp_dq;
        idx = int'(addr[6:0]) * 2;
        address = addr; wdata = data; mem_w_en = 1'b1; mem_r_en = both;
        #1;
        vectors++;
        if (ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s req_ready: got %b want 0", tag, ready);
        end
        for (int n = 1; n <= 20 && ready_at < 0; n++) begin
            @(posedge clk); #1;
            if (n <= 4) begin
                p = (n - 1) / 2;
                exp_pins = {1'b0, 17'(addr[16:0]), p[0], 1'b0, 1'b1,
                            ((n - 1) % 2) != 0, 3'b001};
                exp_dq   = (p == 1) ? data[31:16] : data[15:0];
                vectors++;
                if (pins() !== exp_pins || sram_dq_o !== exp_dq) begin
                    miscompares++;
                    $display("FAIL %s pins_c%0d: got %h/%h want %h/%h",
                             tag, n, pins(), sram_dq_o, exp_pins, exp_dq);
                end
            end
            if (!sram_we_n && !sram_ce_n) begin
                mem[sram_addr[7:0]] = sram_dq_o;
                we_lows++;
            end
            if (n == 1) begin address = 32'h0; wdata = 32'h0; end
            if (n == 2 && !both) mem_w_en = 1'b0;
            if (ready === 1'b1) begin
                ready_at = n;
                mem_w_en = 1'b0; mem_r_en = 1'b0;
            end
        end
        vectors++;
        if (ready_at != 5) begin
            miscompares++;
            $display("FAIL %s ready_cycle: got %0d want 5", tag, ready_at);
        end
        vectors++;
        if (we_lows != 2) begin
            miscompares++;
            $display("FAIL %s we_low_clocks: got %0d want 2", tag, we_lows);
        end
        vectors++;
        if (mem[idx] !== data[15:0] || mem[idx + 1] !== data[31:16]) begin
            miscompares++;
            $display("FAIL %s sram_contents: got %h_%h want %h", tag,
                     mem[idx + 1], mem[idx], data);
        end
        vectors++;
        if (rdata !== exp_rd) begin
            miscompares++;
            $display("FAIL %s rdata_kept: got %h want %h", tag, rdata, exp_rd);
        end
        @(posedge clk); #1;
        vectors++;
        if (pins() !== IDLE_PINS) begin
            miscompares++;
            $display("FAIL %s back_to_idle: got %h want %h", tag, pins(), IDLE_PINS);
        end
    endtask

    // Word 0xB lies in the block starting at halfword {0xB>>1, 2'b00} = 20.
    task automatic test_read;
        run_read(32'h0000_000B, block_20_23, "read");
    endtask

    task automatic test_write;
        run_write(32'h0000_0007, 32'hBEEF_CAFE, 1'b0, block_20_23, "write");
    endtask

    task automatic test_both_requests;
        run_write(32'h0000_0003, 32'h1234_5678, 1'b1, block_20_23, "both_req");
    endtask

    task automatic test_reset_mid_read;
        address = 32'h0000_000B; mem_r_en = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        vectors++;
        if (sram_addr !== 18'd22) begin
            miscompares++;
            $display("FAIL midrst_phase2_addr: got %0d want 22", sram_addr);
        end
        rst = 1'b1; mem_r_en = 1'b0;
        #1;
        vectors++;
        if (pins() !== IDLE_PINS || sram_dq_o !== 16'h0) begin
            miscompares++;
            $display("FAIL midrst_pins: got %h/%h want %h/0000", pins(), sram_dq_o, IDLE_PINS);
        end
        vectors++;
        if (rdata !== 64'h0) begin
            miscompares++;
            $display("FAIL midrst_rdata: got %h want 0", rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_read(32'h0000_000B, block_20_23, "read_after_rst");
    endtask

    // W=1: 4 RD clocks, 1 DONE, 1 IDLE -> ready on cycles 5, 11, 17, 23.
    task automatic test_back_to_back;
        logic exp_r;
        address_1 = 32'h0; mem_r_en_1 = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk); #1;
            exp_r = ((n % 6) == 5);
            vectors++;
            if (ready_1 !== exp_r) begin
                miscompares++;
                $display("FAIL b2b_ready_c%0d: got %b want %b", n, ready_1, exp_r);
            end
            if (exp_r) begin
                vectors++;
                if (rdata_1 !== 64'hA003_A002_A001_A000) begin
                    miscompares++;
                    $display("FAIL b2b_rdata_c%0d: got %h want a003a002a001a000", n, rdata_1);
                end
            end
`ifdef SRAM_PERF_CNT_EN
            if ((n % 6) == 0) begin
                vectors++;
                if (rd_count_1 !== 32'(n / 6) || wr_count_1 !== 32'd0) begin
                    miscompares++;
                    $display("FAIL b2b_counts_c%0d: got rd=%0d wr=%0d want rd=%0d wr=0",
                             n, rd_count_1, wr_count_1, n / 6);
                end
            end
`endif
        end
        mem_r_en_1 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[20] = 16'h1111; mem[21] = 16'h2222;
        mem[22] = 16'h3333; mem[23] = 16'h4444;
        test_reset;
        test_read;
        test_write;
        test_both_requests;
        test_reset_mid_read;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
